fetch_seq_ctrl: RTL

//  Fetch sequencer for the PC register. Each cycle it picks the next PC, drives the PC load enable
//  and runs the req/ack handshake with instruction memory. It handles stalls from the hazard unit,

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_seq_ctrl_redirect_sel.sv | 58 +++++
 rtl/fetch_seq_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, redirect sources and fixed vectors.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   // Numeric value doubles as redirect priority: a larger value wins.
   typedef enum logic [2:0] {
      RS_NONE = 3'd0,
      RS_BR   = 3'd1,
      RS_JUMP = 3'd2,
      RS_ERET = 3'd3,
      RS_EXC  = 3'd4
   } redir_src_e;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

   // A newer redirect replaces a pending one unless it ranks lower.
   function automatic logic src_overrides(input logic [2:0] new_src, input logic [2:0] old_src);
      return (new_src >= old_src);
   endfunction

endpackage

// File: rtl/fetch_seq_ctrl_redirect_sel.sv
// Priority mux over the redirect sources; misaligned targets are diverted to the exception vector.
module redirect_sel
   import cpu_pkg::*;
#(
   parameter logic [31:0] EXC_VEC = cpu_pkg::EXC_VEC
) (
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] target,
   output logic [2:0]  src,
   output logic        redirect_now,
   output logic        misaligned
);

   logic [31:0] raw_target_s;
   redir_src_e  raw_src_s;

   // Fixed priority: exception, eret, jump, branch.
   always_comb begin
      raw_target_s = 32'h0000_0000;
      raw_src_s    = RS_NONE;
      if (exc_req) begin
         raw_target_s = EXC_VEC;
         raw_src_s    = RS_EXC;
      end else if (eret) begin
         raw_target_s = epc;
         raw_src_s    = RS_ERET;
      end else if (jump) begin
         raw_target_s = jump_target;
         raw_src_s    = RS_JUMP;
      end else if (br_taken) begin
         raw_target_s = br_target;
         raw_src_s    = RS_BR;
      end else begin
         raw_target_s = 32'h0000_0000;
         raw_src_s    = RS_NONE;
      end
   end

   // A misaligned target turns into an exception entry and ranks as one.
   always_comb begin
      redirect_now = (raw_src_s != RS_NONE);
      misaligned   = redirect_now && (raw_target_s[1:0] != 2'b00);
      if (misaligned) begin
         target = EXC_VEC;
         src    = RS_EXC;
      end else begin
         target = raw_target_s;
         src    = raw_src_s;
      end
   end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: chooses the next PC, drives the PC load enable and the IMEM req/ack handshake.
module fetch_seq_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [31:0] EXC_VEC  = cpu_pkg::EXC_VEC,
   parameter int          MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] npc,
   output logic        pc_en,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic        stall_in,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        exc_req,
   output logic        if_valid,
   output logic        fetch_err,
   output logic        addr_err
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   fetch_state_e      state_r;
   fetch_state_e      next_state_s;
   logic              pend_valid_r;
   logic [31:0]       pend_target_r;
   logic [2:0]        pend_src_r;
   logic [WAIT_W-1:0] wait_cnt_r;

   logic              pend_valid_nx_s;
   logic [31:0]       pend_target_nx_s;
   logic [2:0]        pend_src_nx_s;
   logic [WAIT_W-1:0] wait_cnt_nx_s;

   logic [31:0]       target_s;
   logic [2:0]        src_s;
   logic              redirect_now_s;
   logic              misaligned_s;

   logic [31:0]       pc_seq_s;
   logic              timeout_s;
   logic              take_new_s;
   logic              steer_s;
   logic [31:0]       merged_target_s;
   logic [2:0]        merged_src_s;

   redirect_sel #(
      .EXC_VEC(EXC_VEC)
   ) u_redirect_sel (
      .exc_req     (exc_req),
      .eret        (eret),
      .epc         (epc),
      .jump        (jump),
      .jump_target (jump_target),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .target      (target_s),
      .src         (src_s),
      .redirect_now(redirect_now_s),
      .misaligned  (misaligned_s)
   );

   assign pc_seq_s  = pc + 32'd4;
   assign timeout_s = (state_r == FETCH) && !imem_ack && (wait_cnt_r == WAIT_LAST);
   // Merge a fresh redirect with one already waiting for the outstanding request.
   assign take_new_s      = redirect_now_s && (!pend_valid_r || src_overrides(src_s, pend_src_r));
   assign merged_target_s = take_new_s ? target_s : pend_target_r;
   assign merged_src_s    = take_new_s ? src_s : pend_src_r;
   assign steer_s         = redirect_now_s || pend_valid_r;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            next_state_s = FETCH;
         end
         FETCH: begin
            if (!timeout_s && imem_ack && !steer_s && stall_in) begin
               next_state_s = HOLD;
            end else begin
               next_state_s = FETCH;
            end
         end
         HOLD: begin
            if (redirect_now_s || !stall_in) begin
               next_state_s = FETCH;
            end else begin
               next_state_s = HOLD;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Output decode; IDLE keeps everything quiet with npc following pc.
   always_comb begin
      npc       = pc;
      pc_en     = 1'b0;
      imem_req  = 1'b0;
      if_valid  = 1'b0;
      fetch_err = 1'b0;
      addr_err  = 1'b0;
      case (state_r)
         IDLE: begin
            pc_en = 1'b0;
         end
         FETCH: begin
            if (timeout_s) begin
               fetch_err = 1'b1;
               pc_en     = 1'b1;
               npc       = EXC_VEC;
            end else begin
               imem_req = 1'b1;
               addr_err = redirect_now_s && misaligned_s;
               if (imem_ack && steer_s) begin
                  pc_en = 1'b1;
                  npc   = merged_target_s;
               end else if (imem_ack && !stall_in) begin
                  if_valid = 1'b1;
                  pc_en    = 1'b1;
                  npc      = pc_seq_s;
               end else if (imem_ack) begin
                  if_valid = 1'b1;
               end else begin
                  pc_en = 1'b0;
               end
            end
         end
         HOLD: begin
            if (redirect_now_s) begin
               pc_en    = 1'b1;
               npc      = target_s;
               addr_err = misaligned_s;
            end else if (!stall_in) begin
               if_valid = 1'b1;
               pc_en    = 1'b1;
               npc      = pc_seq_s;
            end else begin
               if_valid = 1'b1;
            end
         end
         default: begin
            pc_en = 1'b0;
         end
      endcase
   end

   // Pending-redirect and ack-timeout bookkeeping; only FETCH keeps anything alive.
   always_comb begin
      pend_valid_nx_s  = pend_valid_r;
      pend_target_nx_s = pend_target_r;
      pend_src_nx_s    = pend_src_r;
      wait_cnt_nx_s    = {WAIT_W{1'b0}};
      if (state_r != FETCH) begin
         pend_valid_nx_s = 1'b0;
      end else if (timeout_s || imem_ack) begin
         pend_valid_nx_s = 1'b0;
      end else if (redirect_now_s) begin
         pend_valid_nx_s  = 1'b1;
         pend_target_nx_s = merged_target_s;
         pend_src_nx_s    = merged_src_s;
      end else begin
         wait_cnt_nx_s = wait_cnt_r + WAIT_W'(1'b1);
      end
   end

   // Pending-redirect and wait counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid_r  <= 1'b0;
         pend_target_r <= RESET_PC;
         pend_src_r    <= RS_NONE;
         wait_cnt_r    <= {WAIT_W{1'b0}};
      end else begin
         pend_valid_r  <= pend_valid_nx_s;
         pend_target_r <= pend_target_nx_s;
         pend_src_r    <= pend_src_nx_s;
         wait_cnt_r    <= wait_cnt_nx_s;
      end
   end

endmodule
